// File: rtl/ulpi_phy_responder_if.sv
// ULPI bus, RX injection stream, TX sink stream and register taps of the PHY responder.
// slave = the PHY responder, master = the link / bench side.
interface ulpi_phy_responder_if;
  logic [7:0] ulpi_data_i;
  logic [7:0] ulpi_data_o;
  logic       ulpi_dir_o;
  logic       ulpi_nxt_o;
  logic       ulpi_stp_i;
  logic [1:0] linestate_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_last_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_last_o;
  logic [7:0] func_ctrl_o;
  logic [7:0] otg_ctrl_o;

  modport slave (
    input  ulpi_data_i, ulpi_stp_i, linestate_i, rx_data_i, rx_valid_i, rx_last_i,
    output ulpi_data_o, ulpi_dir_o, ulpi_nxt_o, rx_ready_o,
           tx_data_o, tx_valid_o, tx_last_o, func_ctrl_o, otg_ctrl_o
  );

  modport master (
    output ulpi_data_i, ulpi_stp_i, linestate_i, rx_data_i, rx_valid_i, rx_last_i,
    input  ulpi_data_o, ulpi_dir_o, ulpi_nxt_o, rx_ready_o,
           tx_data_o, tx_valid_o, tx_last_o, func_ctrl_o, otg_ctrl_o
  );
endinterface

// File: rtl/ulpi_phy_responder.sv
// ULPI PHY stand-in: decodes link TX CMDs, sinks transmit bytes, injects RX packets.
// Define ULPI_PHY_RXCMD_EN for unsolicited RX CMDs on linestate changes seen in IDLE.
module ulpi_phy_responder #(
  parameter logic [7:0] FUNC_CTRL_RST = 8'h41,
  parameter logic [7:0] OTG_CTRL_RST  = 8'h06,
  parameter logic [1:0] VBUS_STATE    = 2'b11
) (
  input logic clk_i,
  input logic rst_n_i,
  ulpi_phy_responder_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, WR_DATA, WR_STP, RD_TURN, RD_DATA, TX,
    RX_TURN, RX_DATA, RX_END, LS_TURN, LS_CMD
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cmd_q;
  logic [7:0] wdata_q, func_q, otg_q, scratch_q, rd_val;
  logic [7:0] tx_data_q;
  logic       tx_valid_q, tx_last_q;
  logic       dir, nxt, rx_ready, accept, ls_event;
  logic [7:0] data_o, rxcmd_active, rxcmd_none;

  assign rxcmd_active = {2'b00, 2'b01, VBUS_STATE, bus.linestate_i};
  assign rxcmd_none   = {2'b00, 2'b00, VBUS_STATE, bus.linestate_i};

`ifdef ULPI_PHY_RXCMD_EN
  logic [1:0] ls_rep_q;
  logic       rxcmd_shown;
  assign ls_event    = bus.linestate_i != ls_rep_q;
  // Any RX CMD on the bus counts as reporting the current linestate.
  assign rxcmd_shown = (state_q == RX_END) || (state_q == LS_CMD) ||
                       ((state_q == RX_DATA) && !bus.rx_valid_i);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i)         ls_rep_q <= 2'b00;
    else if (rxcmd_shown) ls_rep_q <= bus.linestate_i;
`else
  assign ls_event = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;

  // nxt answers the TxCmd in the same cycle, as a real PHY throttle does.
  always_comb begin
    state_d  = state_q;
    dir      = 1'b0;
    nxt      = 1'b0;
    data_o   = 8'h00;
    rx_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_valid_i)   state_d = RX_TURN;
        else if (ls_event)    state_d = LS_TURN;
        else if (bus.ulpi_data_i[7:6] != 2'b00) begin
          accept = 1'b1;
          nxt    = 1'b1;
          case (bus.ulpi_data_i[7:6])
            2'b01:   state_d = TX;
            2'b10:   state_d = WR_DATA;
            default: state_d = RD_TURN;
          endcase
        end
      end
      WR_DATA: begin
        nxt     = 1'b1;
        state_d = bus.ulpi_stp_i ? IDLE : WR_STP;
      end
      WR_STP:  if (bus.ulpi_stp_i) state_d = IDLE;
      RD_TURN: begin dir = 1'b1; state_d = RD_DATA; end
      RD_DATA: begin dir = 1'b1; data_o = rd_val; state_d = IDLE; end
      TX: begin
        nxt = !bus.ulpi_stp_i;
        if (bus.ulpi_stp_i) state_d = IDLE;
      end
      RX_TURN: begin dir = 1'b1; nxt = 1'b1; state_d = RX_DATA; end
      RX_DATA: begin
        dir = 1'b1;
        if (bus.rx_valid_i) begin
          nxt      = 1'b1;
          data_o   = bus.rx_data_i;
          rx_ready = 1'b1;
          if (bus.rx_last_i) state_d = RX_END;
        end else begin
          data_o = rxcmd_active;
        end
      end
      RX_END:  begin dir = 1'b1; data_o = rxcmd_none; state_d = IDLE; end
      LS_TURN: begin dir = 1'b1; state_d = LS_CMD; end
      LS_CMD:  begin dir = 1'b1; data_o = rxcmd_none; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cmd_q   <= 6'h00;
      wdata_q <= 8'h00;
    end else begin
      if (accept)              cmd_q   <= bus.ulpi_data_i[5:0];
      if (state_q == WR_DATA)  wdata_q <= bus.ulpi_data_i;
    end

  // Each register has base / OR-set / AND-clear aliases; only a completed write lands.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      func_q    <= FUNC_CTRL_RST;
      otg_q     <= OTG_CTRL_RST;
      scratch_q <= 8'h00;
    end else if (state_q == WR_STP && bus.ulpi_stp_i) begin
      case (cmd_q)
        6'h04:   func_q    <= wdata_q;
        6'h05:   func_q    <= func_q | wdata_q;
        6'h06:   func_q    <= func_q & ~wdata_q;
        6'h0A:   otg_q     <= wdata_q;
        6'h0B:   otg_q     <= otg_q | wdata_q;
        6'h0C:   otg_q     <= otg_q & ~wdata_q;
        6'h16:   scratch_q <= wdata_q;
        6'h17:   scratch_q <= scratch_q | wdata_q;
        6'h18:   scratch_q <= scratch_q & ~wdata_q;
        default: ;
      endcase
    end

  always_comb begin
    rd_val = 8'h00;
    case (cmd_q)
      6'h04, 6'h05, 6'h06: rd_val = func_q;
      6'h0A, 6'h0B, 6'h0C: rd_val = otg_q;
      6'h16, 6'h17, 6'h18: rd_val = scratch_q;
      default:             ;
    endcase
  end

  // Transmit sink: PID byte right after the TxCmd, then each byte one cycle late.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      if (accept && bus.ulpi_data_i[7:6] == 2'b01) begin
        tx_data_q  <= {~bus.ulpi_data_i[3:0], bus.ulpi_data_i[3:0]};
        tx_valid_q <= 1'b1;
      end else if (state_q == TX) begin
        if (bus.ulpi_stp_i) tx_last_q <= 1'b1;
        else begin
          tx_data_q  <= bus.ulpi_data_i;
          tx_valid_q <= 1'b1;
        end
      end
    end

  assign bus.ulpi_dir_o  = dir;
  assign bus.ulpi_nxt_o  = nxt & rst_n_i;
  assign bus.ulpi_data_o = data_o;
  assign bus.rx_ready_o  = rx_ready;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.tx_valid_o  = tx_valid_q;
  assign bus.tx_last_o   = tx_last_q;
  assign bus.func_ctrl_o = func_q;
  assign bus.otg_ctrl_o  = otg_q;

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Bench for ulpi_phy_responder: randomized link/RX traffic against a register/stream model,
// with a queue scoreboard checked by an independent bus/stream monitor.
module tb_ulpi_phy_responder;
  localparam logic [7:0] FUNC_RST = 8'h41;
  localparam logic [7:0] OTG_RST  = 8'h06;
  localparam logic [1:0] VBUS     = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #8 clk = ~clk;

  ulpi_phy_responder_if bus ();
  ulpi_phy_responder #(.FUNC_CTRL_RST(FUNC_RST), .OTG_CTRL_RST(OTG_RST), .VBUS_STATE(VBUS))
    dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  typedef struct { bit nxt; bit care; logic [7:0] data; bit last; } bexp_t;
  typedef struct { bit valid; bit last; logic [7:0] data; } texp_t;

  bexp_t burst_q[$];
  texp_t tx_q[$];
  logic [7:0] rxb[$];
  int         rxg[$];
  logic [7:0] txb[$];
  int errors = 0;
  int checks = 0;
  logic [7:0] m_func, m_otg, m_scr;
  logic [1:0] m_ls_rep;

  function automatic void chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endfunction

  function automatic void chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endfunction

  // Register model: three registers, each at base / base+1 (set) / base+2 (clear).
  function automatic int reg_base(input logic [5:0] a);
    if (a >= 6'h04 && a <= 6'h06) return 4;
    if (a >= 6'h0A && a <= 6'h0C) return 10;
    if (a >= 6'h16 && a <= 6'h18) return 22;
    return -1;
  endfunction

  function automatic logic [7:0] model_read(input logic [5:0] a);
    case (reg_base(a))
      4:       return m_func;
      10:      return m_otg;
      22:      return m_scr;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model_write(input logic [5:0] a, input logic [7:0] d);
    int b;
    logic [7:0] r;
    b = reg_base(a);
    if (b < 0) return;
    r = model_read(a);
    if (int'(a) == b)          r = d;
    else if (int'(a) == b + 1) r = r | d;
    else                       r = r & ~d;
    if (b == 4) m_func = r;
    else if (b == 10) m_otg = r;
    else m_scr = r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every dir-high cycle and every tx stream event consumes one expectation.
  bit in_burst = 1'b0;
  bit last_end = 1'b0;
  bexp_t mon_b;
  texp_t mon_t;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ulpi_dir_o) begin
        if (burst_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: dir=1 data 0x%02h, want dir=0", bus.ulpi_data_o);
        end else begin
          mon_b = burst_q.pop_front();
          chk1("bus_nxt", bus.ulpi_nxt_o, mon_b.nxt);
          if (mon_b.care) chk8("bus_data", bus.ulpi_data_o, mon_b.data);
          last_end = mon_b.last;
        end
        in_burst = 1'b1;
      end else if (in_burst) begin
        in_burst = 1'b0;
        chk1("bus_burst_end", last_end, 1'b1);
      end
      if (bus.tx_valid_o || bus.tx_last_o) begin
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: valid=%b last=%b data 0x%02h, want idle",
                   bus.tx_valid_o, bus.tx_last_o, bus.tx_data_o);
        end else begin
          mon_t = tx_q.pop_front();
          chk1("tx_valid", bus.tx_valid_o, mon_t.valid);
          chk1("tx_last", bus.tx_last_o, mon_t.last);
          if (mon_t.valid) chk8("tx_data", bus.tx_data_o, mon_t.data);
        end
      end
    end
  end

  task automatic do_write(input logic [5:0] a, input logic [7:0] d, input bit early);
    bus.ulpi_data_i = {2'b10, a};
    @(negedge clk); chk1("wr_cmd_nxt", bus.ulpi_nxt_o, 1'b1);
    step();
    bus.ulpi_data_i = d;
    bus.ulpi_stp_i  = early;
    @(negedge clk); if (!early) chk1("wr_data_nxt", bus.ulpi_nxt_o, 1'b1);
    step();
    if (!early) begin
      bus.ulpi_data_i = 8'h00;
      bus.ulpi_stp_i  = 1'b1;
      @(negedge clk); chk1("wr_stp_nxt", bus.ulpi_nxt_o, 1'b0);
      step();
      model_write(a, d);
    end
    bus.ulpi_data_i = 8'h00;
    bus.ulpi_stp_i  = 1'b0;
    @(negedge clk);
    chk8("func_ctrl", bus.func_ctrl_o, m_func);
    chk8("otg_ctrl", bus.otg_ctrl_o, m_otg);
    step();
  endtask

  task automatic do_read(input logic [5:0] a);
    bus.ulpi_data_i = {2'b11, a};
    burst_q.push_back('{1'b0, 1'b0, 8'h00, 1'b0});
    burst_q.push_back('{1'b0, 1'b1, model_read(a), 1'b1});
    @(negedge clk);
    chk1("rd_cmd_nxt", bus.ulpi_nxt_o, 1'b1);
    chk1("rd_cmd_dir", bus.ulpi_dir_o, 1'b0);
    step();
    bus.ulpi_data_i = 8'h00;
    bus.ulpi_stp_i  = 1'($urandom);
    step();
    bus.ulpi_stp_i  = 1'($urandom);
    step();
    bus.ulpi_stp_i  = 1'b0;
    step();
  endtask

  task automatic do_tx(input logic [3:0] pid);
    bus.ulpi_data_i = {4'b0100, pid};
    tx_q.push_back('{1'b1, 1'b0, {~pid, pid}});
    @(negedge clk); chk1("tx_cmd_nxt", bus.ulpi_nxt_o, 1'b1);
    foreach (txb[i]) begin
      step();
      bus.ulpi_data_i = txb[i];
      tx_q.push_back('{1'b1, 1'b0, txb[i]});
      @(negedge clk); chk1("tx_data_nxt", bus.ulpi_nxt_o, 1'b1);
    end
    step();
    bus.ulpi_data_i = 8'h00;
    bus.ulpi_stp_i  = 1'b1;
    tx_q.push_back('{1'b0, 1'b1, 8'h00});
    @(negedge clk); chk1("tx_stp_nxt", bus.ulpi_nxt_o, 1'b0);
    step();
    bus.ulpi_stp_i = 1'b0;
    step();
  endtask

  task automatic set_ls(input logic [1:0] v);
    bus.linestate_i = v;
`ifdef ULPI_PHY_RXCMD_EN
    if (v != m_ls_rep) begin
      burst_q.push_back('{1'b0, 1'b0, 8'h00, 1'b0});
      burst_q.push_back('{1'b0, 1'b1, {4'b0000, VBUS, v}, 1'b1});
      m_ls_rep = v;
    end
    repeat (4) step();
`else
    repeat (4) begin
      @(negedge clk); chk1("ls_no_dir", bus.ulpi_dir_o, 1'b0);
      step();
    end
`endif
  endtask

  task automatic do_rx(input logic [7:0] collide, input logic [1:0] ls, input bit noisy);
    int rdy;
    logic [7:0] act_cmd, end_cmd;
    set_ls(ls);
    act_cmd = {4'b0001, VBUS, ls};
    end_cmd = {4'b0000, VBUS, ls};
    burst_q.push_back('{1'b1, 1'b0, 8'h00, 1'b0});
    foreach (rxb[k]) begin
      for (int g = 0; g < rxg[k]; g++) burst_q.push_back('{1'b0, 1'b1, act_cmd, 1'b0});
      burst_q.push_back('{1'b1, 1'b1, rxb[k], 1'b0});
    end
    burst_q.push_back('{1'b0, 1'b1, end_cmd, 1'b1});
    rdy = 0;
    bus.rx_valid_i  = 1'b1;
    bus.rx_data_i   = rxb[0];
    bus.rx_last_i   = (rxb.size() == 1);
    bus.ulpi_data_i = collide;
    @(negedge clk); chk1("rx_collide_nxt", bus.ulpi_nxt_o, 1'b0);
    step();
    bus.ulpi_data_i = 8'h00;
    if (noisy) bus.ulpi_stp_i = 1'($urandom);
    @(negedge clk); rdy += int'(bus.rx_ready_o);
    foreach (rxb[k]) begin
      for (int g = 0; g < rxg[k]; g++) begin
        step();
        bus.rx_valid_i = 1'b0;
        if (noisy) bus.ulpi_stp_i = 1'($urandom);
        @(negedge clk); rdy += int'(bus.rx_ready_o);
      end
      step();
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = rxb[k];
      bus.rx_last_i  = (k == rxb.size() - 1);
      if (noisy) bus.ulpi_stp_i = 1'($urandom);
      @(negedge clk); chk1("rx_ready", bus.rx_ready_o, 1'b1);
      rdy += int'(bus.rx_ready_o);
    end
    step();
    bus.rx_valid_i = 1'b0;
    bus.rx_last_i  = 1'b0;
    bus.ulpi_stp_i = 1'b0;
    @(negedge clk); rdy += int'(bus.rx_ready_o);
    step();
    chki("rx_ready_count", rdy, rxb.size());
  endtask

  task automatic pulse_reset(input string tag);
    bus.ulpi_data_i = 8'h84;
    rst_n = 1'b0;
    #2;
    chk1({tag, "_dir"}, bus.ulpi_dir_o, 1'b0);
    chk1({tag, "_nxt"}, bus.ulpi_nxt_o, 1'b0);
    chk8({tag, "_data"}, bus.ulpi_data_o, 8'h00);
    chk1({tag, "_rx_ready"}, bus.rx_ready_o, 1'b0);
    chk1({tag, "_tx_valid"}, bus.tx_valid_o, 1'b0);
    chk1({tag, "_tx_last"}, bus.tx_last_o, 1'b0);
    chk8({tag, "_func"}, bus.func_ctrl_o, FUNC_RST);
    chk8({tag, "_otg"}, bus.otg_ctrl_o, OTG_RST);
    step();
    rst_n = 1'b1;
    bus.ulpi_data_i = 8'h00;
    bus.ulpi_stp_i  = 1'b0;
    m_func = FUNC_RST; m_otg = OTG_RST; m_scr = 8'h00; m_ls_rep = 2'b00;
    step();
  endtask

  function automatic logic [5:0] pick_addr();
    logic [5:0] hot[9] = '{6'h04, 6'h05, 6'h06, 6'h0A, 6'h0B, 6'h0C, 6'h16, 6'h17, 6'h18};
    if ($urandom_range(0, 3) != 0) return hot[$urandom_range(0, 8)];
    return 6'($urandom);
  endfunction

  initial begin
    bus.ulpi_data_i = 8'h84;
    bus.ulpi_stp_i  = 1'b0;
    bus.linestate_i = 2'b00;
    bus.rx_data_i   = 8'h00;
    bus.rx_valid_i  = 1'b0;
    bus.rx_last_i   = 1'b0;
    m_func = FUNC_RST; m_otg = OTG_RST; m_scr = 8'h00; m_ls_rep = 2'b00;

    repeat (3) @(negedge clk);
    chk1("reset_dir", bus.ulpi_dir_o, 1'b0);
    chk1("reset_nxt", bus.ulpi_nxt_o, 1'b0);
    chk8("reset_data", bus.ulpi_data_o, 8'h00);
    chk1("reset_rx_ready", bus.rx_ready_o, 1'b0);
    chk1("reset_tx_valid", bus.tx_valid_o, 1'b0);
    chk1("reset_tx_last", bus.tx_last_o, 1'b0);
    chk8("reset_func", bus.func_ctrl_o, FUNC_RST);
    chk8("reset_otg", bus.otg_ctrl_o, OTG_RST);
    step();
    rst_n = 1'b1;
    bus.ulpi_data_i = 8'h00;
    step();

    // Directed cases from the block's intended use.
    do_read(6'h0A);
    do_read(6'h3F);
    do_write(6'h04, 8'h48, 1'b0);
    do_write(6'h05, 8'h01, 1'b0);
    do_write(6'h06, 8'h40, 1'b0);
    do_read(6'h06);
    do_write(6'h16, 8'hEE, 1'b1);
    do_read(6'h16);
    txb = '{8'h11, 8'h22};
    do_tx(4'h3);
    rxb = '{8'hA5, 8'h01, 8'h02};
    rxg = '{0, 0, 0};
    do_rx(8'h84, 2'b01, 1'b0);
    do_read(6'h04);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 4))
        0: do_write(pick_addr(), 8'($urandom), ($urandom_range(0, 9) == 0));
        1: do_read(pick_addr());
        2: begin
          txb.delete();
          repeat ($urandom_range(0, 4)) txb.push_back(8'($urandom));
          do_tx(4'($urandom));
        end
        3: begin
          rxb.delete();
          rxg.delete();
          repeat ($urandom_range(1, 5)) begin
            rxb.push_back(8'($urandom));
            rxg.push_back((rxb.size() == 1) ? 0 : $urandom_range(0, 2));
          end
          do_rx(($urandom_range(0, 1) != 0) ? {2'($urandom_range(1, 3)), 6'($urandom)} : 8'h00,
                2'($urandom), 1'b1);
        end
        default: begin
          bus.ulpi_data_i = {2'b00, 6'($urandom_range(1, 63))};
          @(negedge clk);
          chk1("noop_nxt", bus.ulpi_nxt_o, 1'b0);
          chk1("noop_dir", bus.ulpi_dir_o, 1'b0);
          step();
          bus.ulpi_data_i = 8'h00;
          step();
        end
      endcase
    end

    // Reset in the stop cycle of a write: outputs clear at once, write is lost.
    set_ls(2'b00);
    do_write(6'h04, 8'h5A, 1'b0);
    do_write(6'h16, 8'h3C, 1'b0);
    bus.ulpi_data_i = {2'b10, 6'h0A};
    @(negedge clk); step();
    bus.ulpi_data_i = 8'hF0;
    @(negedge clk); step();
    bus.ulpi_data_i = 8'h00;
    bus.ulpi_stp_i  = 1'b1;
    pulse_reset("rst_wr");
    do_read(6'h04);
    do_read(6'h0A);
    do_read(6'h16);

    // Reset while the transmit sink is presenting a byte.
    bus.ulpi_data_i = 8'h4A;
    tx_q.push_back('{1'b1, 1'b0, 8'h5A});
    @(negedge clk); step();
    bus.ulpi_data_i = 8'h33;
    @(negedge clk); step();
    pulse_reset("rst_tx");
    do_read(6'h05);

    chki("burst_q_drained", burst_q.size(), 0);
    chki("tx_q_drained", tx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
